// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C target (and the master side): the target FSM
// state type and the byte-length constants used by the bit counter.
// No ports.
// -----------------------------------------------------------------------------
package i2c_pkg;

   localparam int BITS_PER_BYTE = 8;

   // Value of the 3-bit bit counter when the last bit of a byte is handled.
   localparam logic [2:0] LAST_BIT_IDX = 3'(BITS_PER_BYTE - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_ACK
   } slave_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// -----------------------------------------------------------------------------
// i2c_sync_edge
// Brings one asynchronous bus line into the clk domain through SYNC_STAGES
// flops, then compares against one extra register to produce edge strobes.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset (all flops go to 1, the idle
//               bus level, so leaving reset never looks like an edge)
//   din    in   raw bus line
//   level  out  synchronized line level
//   rise   out  one-cycle strobe, level went 0 -> 1
//   fall   out  one-cycle strobe, level went 1 -> 0
// -----------------------------------------------------------------------------
module i2c_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q[0] <= din;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// -----------------------------------------------------------------------------
// i2c_slave
// I2C target with a 7-bit address. Receives write bytes into rx_data, returns
// read bytes taken from tx_data, never stretches scl. START/STOP are detected
// in every state and take priority over a coincident scl edge.
//
// Ports:
//   clk       in     system clock
//   reset     in     synchronous active-high reset
//   scl       in     I2C clock from the master
//   sda       inout  open-drain data, driven only to 0 or z
//   tx_data   in     [7:0] next read byte, sampled the cycle after tx_req
//   tx_req    out    one-cycle request for the next read byte
//   rx_data   out    [7:0] last written byte, held until the next one
//   rx_valid  out    one-cycle strobe when rx_data updates
//   addr_hit  out    high from the address ACK until STOP or START
//   rw        out    R/W bit of the current matched transfer (1 = read)
//   busy      out    high between START and STOP
// -----------------------------------------------------------------------------
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = 7'h42,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   inout  wire        sda,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       addr_hit,
   output logic       rw,
   output logic       busy
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic start_det, stop_det;

   slave_state_t state_q, state_d;
   logic [2:0]   bit_cnt_q, bit_cnt_d;
   logic [7:0]   shift_q, shift_d;
   logic [7:0]   shifted;
   logic         sda_oe_q, sda_oe_d;
   logic         byte_full_q, byte_full_d;   // 8 bits in, waiting for the ACK fall
   logic         ack_ok_q, ack_ok_d;         // master ACKed a read byte
   logic [7:0]   rx_data_d;
   logic         rx_valid_d, tx_req_d, addr_hit_d, rw_d, busy_d;

   i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
      .clk   (clk),
      .reset (reset),
      .din   (scl),
      .level (scl_lvl),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
      .clk   (clk),
      .reset (reset),
      .din   (sda),
      .level (sda_lvl),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   // Both lines share the same latency, so the scl level seen here is the one
   // that coincided with the sda transition on the bus.
   assign start_det = sda_fall & scl_lvl;
   assign stop_det  = sda_rise & scl_lvl;

   assign shifted = {shift_q[6:0], sda_lvl};

   // Reset gates the driver directly so the line is released in the very
   // cycle reset is applied, not one clock later.
   assign sda = (sda_oe_q && !reset) ? 1'b0 : 1'bz;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         sda_oe_q    <= 1'b0;
         byte_full_q <= 1'b0;
         ack_ok_q    <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         tx_req      <= 1'b0;
         addr_hit    <= 1'b0;
         rw          <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         sda_oe_q    <= sda_oe_d;
         byte_full_q <= byte_full_d;
         ack_ok_q    <= ack_ok_d;
         rx_data     <= rx_data_d;
         rx_valid    <= rx_valid_d;
         tx_req      <= tx_req_d;
         addr_hit    <= addr_hit_d;
         rw          <= rw_d;
         busy        <= busy_d;
      end
   end

   always_comb begin
      // NOTE: every value written below gets a default first, so no branch can
      // leave one unassigned and infer a latch.
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      sda_oe_d    = sda_oe_q;
      byte_full_d = byte_full_q;
      ack_ok_d    = ack_ok_q;
      rx_data_d   = rx_data;
      rx_valid_d  = 1'b0;
      tx_req_d    = 1'b0;
      addr_hit_d  = addr_hit;
      rw_d        = rw;
      busy_d      = busy;

      // The requested read byte arrives one cycle after the request strobe.
      if (tx_req) begin
         shift_d = tx_data;
      end

      if (start_det) begin
         state_d     = ST_ADDR;
         bit_cnt_d   = '0;
         sda_oe_d    = 1'b0;
         byte_full_d = 1'b0;
         ack_ok_d    = 1'b0;
         addr_hit_d  = 1'b0;
         busy_d      = 1'b1;
      end else if (stop_det) begin
         state_d     = ST_IDLE;
         bit_cnt_d   = '0;
         sda_oe_d    = 1'b0;
         byte_full_d = 1'b0;
         ack_ok_d    = 1'b0;
         addr_hit_d  = 1'b0;
         busy_d      = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // Wait for START; bus edges are ignored here.
            end

            ST_ADDR: begin
               if (scl_rise) begin
                  shift_d   = shifted;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == LAST_BIT_IDX) begin
                     // shift_q[6:0] already holds address bits 7..1.
                     if (shift_q[6:0] == SLAVE_ADDR) begin
                        byte_full_d = 1'b1;
                        rw_d        = sda_lvl;
                        tx_req_d    = sda_lvl;
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end
               end else if (scl_fall && byte_full_q) begin
                  byte_full_d = 1'b0;
                  sda_oe_d    = 1'b1;
                  addr_hit_d  = 1'b1;
                  state_d     = ST_ADDR_ACK;
               end
            end

            ST_ADDR_ACK: begin
               // The fall after the 9th high ends the ACK slot.
               if (scl_fall) begin
                  if (rw) begin
                     sda_oe_d = ~shift_q[7];
                     state_d  = ST_RD_DATA;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = ST_WR_DATA;
                  end
               end
            end

            ST_WR_DATA: begin
               if (scl_rise) begin
                  shift_d   = shifted;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == LAST_BIT_IDX) begin
                     rx_data_d   = shifted;
                     rx_valid_d  = 1'b1;
                     byte_full_d = 1'b1;
                  end
               end else if (scl_fall && byte_full_q) begin
                  byte_full_d = 1'b0;
                  sda_oe_d    = 1'b1;
                  state_d     = ST_WR_ACK;
               end
            end

            ST_WR_ACK: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  state_d  = ST_WR_DATA;
               end
            end

            ST_RD_DATA: begin
               // Bit 7 went out before the first rise; each fall presents the
               // next bit, and the 8th fall hands the line to the master.
               if (scl_fall) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == LAST_BIT_IDX) begin
                     sda_oe_d = 1'b0;
                     ack_ok_d = 1'b0;
                     state_d  = ST_RD_ACK;
                  end else begin
                     sda_oe_d = ~shift_q[6];
                     shift_d  = {shift_q[6:0], 1'b0};
                  end
               end
            end

            ST_RD_ACK: begin
               if (scl_rise) begin
                  if (!sda_lvl) begin
                     tx_req_d = 1'b1;
                     ack_ok_d = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else if (scl_fall && ack_ok_q) begin
                  ack_ok_d = 1'b0;
                  sda_oe_d = ~shift_q[7];
                  state_d  = ST_RD_DATA;
               end
            end

            default: begin
               state_d  = ST_IDLE;
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave
// Bit-level I2C master driving i2c_slave with a 1000-clk scl period. The
// expected bus level for every scl-high slot comes from transaction-level
// rules (address match => ACK, read slots carry the queued byte MSB first,
// otherwise the target leaves the line alone), and one process compares the
// resolved sda line against it on every clk of every scl-high phase. Written
// and read bytes are matched against queues of expected bytes.
// -----------------------------------------------------------------------------
module tb_i2c_slave;

   localparam logic [6:0] SLAVE_ADDR = 7'h42;
   localparam int         QTR        = 250;   // quarter of the scl period

   logic       clk     = 1'b0;
   logic       reset   = 1'b1;
   logic       scl     = 1'b1;
   logic       m_low   = 1'b0;     // master pulls sda low
   logic [7:0] tx_data = 8'h00;
   logic       tx_req;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       addr_hit;
   logic       rw;
   logic       busy;
   wire        sda;

   int tests  = 0;
   int fails  = 0;
   int rx_cnt = 0;
   int tx_cnt = 0;

   logic       chk_en  = 1'b0;
   logic       chk_exp = 1'b1;
   logic [7:0] exp_rx_q[$];
   logic [7:0] tx_q[$];

   assign sda = m_low ? 1'b0 : 1'bz;
   pullup (sda);

   always #5 clk = ~clk;

   i2c_slave #(
      .SLAVE_ADDR  (SLAVE_ADDR),
      .SYNC_STAGES (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .scl      (scl),
      .sda      (sda),
      .tx_data  (tx_data),
      .tx_req   (tx_req),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .addr_hit (addr_hit),
      .rw       (rw),
      .busy     (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic addr_match(input logic [7:0] b);
      return b[7:1] == SLAVE_ADDR;
   endfunction

   // Compare process: bus level during scl-high slots, and every written byte.
   always @(negedge clk) begin
      if (chk_en) check("sda_bus", sda, chk_exp);
      if (rx_valid) begin
         rx_cnt++;
         if (exp_rx_q.size() == 0) check("rx_valid_unexpected", rx_valid, 1'b0);
         else                      check("rx_data", rx_data, exp_rx_q.pop_front());
      end
   end

   // Application side: answer each read request with the next queued byte.
   initial begin
      forever begin
         @(negedge clk);
         if (tx_req) begin
            tx_cnt++;
            tx_data = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hFF;
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
   endtask

   // One scl period: data set mid-low, bus checked throughout the high phase.
   task automatic bus_bit(input logic b, input logic exp_bus, output logic got);
      wait_clk(QTR); m_low = ~b;
      wait_clk(QTR); scl = 1'b1;
      chk_exp = exp_bus;
      wait_clk(2); chk_en = 1'b1;
      wait_clk(QTR - 2); got = sda;
      wait_clk(QTR - 2); chk_en = 1'b0;
      wait_clk(2); scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic exp_ack, output logic acked);
      logic got;
      for (int i = 7; i >= 0; i--) bus_bit(d[i], d[i], got);
      bus_bit(1'b1, ~exp_ack, got);
      acked = ~got;
   endtask

   task automatic recv_byte(input logic [7:0] exp_byte, input logic m_ack, output logic [7:0] got);
      logic b;
      got = '0;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(1'b1, exp_byte[i], b);
         got[i] = b;
      end
      bus_bit(~m_ack, ~m_ack, b);
   endtask

   task automatic start_cond();
      if (scl == 1'b0) begin
         wait_clk(QTR); m_low = 1'b0;
         wait_clk(QTR); scl = 1'b1;
      end
      wait_clk(QTR); m_low = 1'b1;
      wait_clk(QTR); scl = 1'b0;
   endtask

   task automatic stop_cond();
      wait_clk(QTR); m_low = 1'b1;
      wait_clk(QTR); scl = 1'b1;
      wait_clk(QTR); m_low = 1'b0;
      wait_clk(QTR);
   endtask

   initial begin
      logic       ack;
      logic       got;
      logic [7:0] rd;
      int         rx0;
      int         tx0;

      // Reset state
      wait_clk(5);
      check("rst_rx_data",  rx_data,  8'h00);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_tx_req",   tx_req,   1'b0);
      check("rst_addr_hit", addr_hit, 1'b0);
      check("rst_rw",       rw,       1'b0);
      check("rst_busy",     busy,     1'b0);
      check("rst_sda",      sda,      1'b1);
      reset = 1'b0;
      wait_clk(10);

      // Reset during the 4th bit of a write byte (0xF0)
      start_cond();
      send_byte(8'h84, addr_match(8'h84), ack);
      check("rst_seq_addr_ack", ack, 1'b1);
      check("rst_seq_addr_hit", addr_hit, 1'b1);
      for (int i = 0; i < 3; i++) bus_bit(1'b1, 1'b1, got);
      wait_clk(QTR); m_low = 1'b0;
      wait_clk(QTR); scl = 1'b1;
      wait_clk(QTR);
      reset = 1'b1;
      #1;
      check("rst_seq_sda_released", sda, 1'b1);
      wait_clk(4);
      check("rst_seq_busy", busy, 1'b0);
      check("rst_seq_addr_hit_clr", addr_hit, 1'b0);
      reset = 1'b0;
      wait_clk(QTR - 5); scl = 1'b0;
      for (int i = 0; i < 4; i++) bus_bit(1'b0, 1'b0, got);
      bus_bit(1'b1, 1'b1, got);
      check("rst_seq_no_ack", got, 1'b1);
      stop_cond();
      check("rst_seq_rx_count", rx_cnt, 0);
      check("rst_seq_busy_idle", busy, 1'b0);

      // Write: 0x84, 0x5A
      rx0 = rx_cnt;
      exp_rx_q.push_back(8'h5A);
      start_cond();
      check("wr_busy_start", busy, 1'b1);
      send_byte(8'h84, addr_match(8'h84), ack);
      check("wr_addr_ack", ack, 1'b1);
      check("wr_addr_hit", addr_hit, 1'b1);
      check("wr_rw", rw, 1'b0);
      send_byte(8'h5A, 1'b1, ack);
      check("wr_data_ack", ack, 1'b1);
      stop_cond();
      check("wr_busy_stop", busy, 1'b0);
      check("wr_addr_hit_stop", addr_hit, 1'b0);
      check("wr_rx_count", rx_cnt - rx0, 1);
      check("wr_rx_data_held", rx_data, 8'h5A);

      // Address miss 0x90, then repeated START and read of 0xC3 with NACK
      rx0 = rx_cnt;
      tx0 = tx_cnt;
      tx_q.push_back(8'hC3);
      start_cond();
      send_byte(8'h90, addr_match(8'h90), ack);
      check("miss_ack", ack, 1'b0);
      check("miss_addr_hit", addr_hit, 1'b0);
      check("miss_busy", busy, 1'b1);
      start_cond();
      send_byte(8'h85, addr_match(8'h85), ack);
      check("rd_addr_ack", ack, 1'b1);
      check("rd_rw", rw, 1'b1);
      recv_byte(8'hC3, 1'b0, rd);
      check("rd_byte", rd, 8'hC3);
      stop_cond();
      check("rd_tx_req_count", tx_cnt - tx0, 1);
      check("rd_busy_stop", busy, 1'b0);
      check("miss_rd_rx_count", rx_cnt - rx0, 0);

      // Write 0x01, repeated START, multi-byte read 0x11 (ACK), 0x22 (NACK)
      rx0 = rx_cnt;
      tx0 = tx_cnt;
      exp_rx_q.push_back(8'h01);
      tx_q.push_back(8'h11);
      tx_q.push_back(8'h22);
      start_cond();
      send_byte(8'h84, addr_match(8'h84), ack);
      check("rs_wr_addr_ack", ack, 1'b1);
      check("rs_rw_write", rw, 1'b0);
      send_byte(8'h01, 1'b1, ack);
      check("rs_wr_data_ack", ack, 1'b1);
      start_cond();
      check("rs_addr_hit_clr", addr_hit, 1'b0);
      check("rs_busy", busy, 1'b1);
      send_byte(8'h85, addr_match(8'h85), ack);
      check("rs_rd_addr_ack", ack, 1'b1);
      check("rs_rw_read", rw, 1'b1);
      check("rs_addr_hit", addr_hit, 1'b1);
      recv_byte(8'h11, 1'b1, rd);
      check("mb_byte0", rd, 8'h11);
      recv_byte(8'h22, 1'b0, rd);
      check("mb_byte1", rd, 8'h22);
      stop_cond();
      check("mb_tx_req_count", tx_cnt - tx0, 2);
      check("rs_rx_count", rx_cnt - rx0, 1);
      check("rs_busy_stop", busy, 1'b0);
      check("rx_all_seen", exp_rx_q.size(), 0);

      wait_clk(10);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
